// File: rtl/cpu_sram_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : cpu_sram_arbiter_if
// Description : SRAM-like request/response bus shared by the fetch, load/store
//               and memory sides of the CPU SRAM arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface cpu_sram_arbiter_if;
    logic        req;
    logic        wr;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] rdata;

    // master issues requests, slave accepts and responds
    modport master (
        output req, wr, wstrb, addr, wdata,
        input  addr_ok, data_ok, rdata
    );

    modport slave (
        input  req, wr, wstrb, addr, wdata,
        output addr_ok, data_ok, rdata
    );
endinterface
`default_nettype wire

// File: rtl/cpu_sram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : cpu_sram_arbiter
// Description : Merges the CPU fetch and load/store SRAM-like ports onto one
//               memory port, one outstanding transaction at a time, data first
//               with a bounded starvation window for fetches.
// Revision    : 1.0 - initial release
// ============================================================================
module cpu_sram_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  wire logic          clk,
    input  wire logic          reset,
    cpu_sram_arbiter_if.slave  inst_bus,
    cpu_sram_arbiter_if.slave  data_bus,
    cpu_sram_arbiter_if.master mem_bus
);

    localparam logic [3:0] c_starve_limit = 4'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    typedef enum logic {
        OWN_INST = 1'b0,
        OWN_DATA = 1'b1
    } owner_t;

    state_t      r_state;
    state_t      w_state_nxt;
    owner_t      r_owner;
    owner_t      w_owner_nxt;
    logic [3:0]  r_starve_cnt;
    logic [3:0]  w_starve_nxt;

    logic        w_any_req;
    logic        w_grant_inst;
    logic        w_owner_data;
    logic        w_unused_inst;

    assign w_any_req    = inst_bus.req | data_bus.req;
    // fetch only beats a pending load/store once the starvation window is used up
    assign w_grant_inst = inst_bus.req & (~data_bus.req | (r_starve_cnt == c_starve_limit));
    assign w_owner_data = (r_owner == OWN_DATA);

    // the fetch port is read-only; its write-side fields are never forwarded
    assign w_unused_inst = ^{inst_bus.wr, inst_bus.wstrb, inst_bus.wdata};

    assign inst_bus.rdata = mem_bus.rdata;
    assign data_bus.rdata = mem_bus.rdata;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_owner      <= OWN_INST;
            r_starve_cnt <= 4'd0;
        end else begin
            r_state      <= w_state_nxt;
            r_owner      <= w_owner_nxt;
            r_starve_cnt <= w_starve_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_owner_nxt      = r_owner;
        w_starve_nxt     = r_starve_cnt;

        mem_bus.req      = 1'b0;
        mem_bus.addr     = w_owner_data ? data_bus.addr  : inst_bus.addr;
        mem_bus.wr       = w_owner_data & data_bus.wr;
        mem_bus.wstrb    = w_owner_data ? data_bus.wstrb : 4'b0000;
        mem_bus.wdata    = w_owner_data ? data_bus.wdata : 32'h0000_0000;

        inst_bus.addr_ok = 1'b0;
        inst_bus.data_ok = 1'b0;
        data_bus.addr_ok = 1'b0;
        data_bus.data_ok = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (w_any_req) begin
                    w_state_nxt = ST_ADDR;
                    if (w_grant_inst) begin
                        w_owner_nxt  = OWN_INST;
                        w_starve_nxt = 4'd0;
                    end else begin
                        w_owner_nxt = OWN_DATA;
                        if (inst_bus.req && (r_starve_cnt < c_starve_limit)) begin
                            w_starve_nxt = r_starve_cnt + 4'd1;
                        end
                    end
                end
            end

            ST_ADDR: begin
                // request follows the owner live, so a withdrawn request drops mem_req
                if (w_owner_data) begin
                    mem_bus.req      = data_bus.req;
                    data_bus.addr_ok = mem_bus.addr_ok;
                end else begin
                    mem_bus.req      = inst_bus.req;
                    inst_bus.addr_ok = mem_bus.addr_ok;
                end
                if (mem_bus.addr_ok) begin
                    w_state_nxt = ST_RESP;
                end
            end

            ST_RESP: begin
                if (w_owner_data) begin
                    data_bus.data_ok = mem_bus.data_ok;
                end else begin
                    inst_bus.data_ok = mem_bus.data_ok;
                end
                if (mem_bus.data_ok) begin
                    w_state_nxt = ST_IDLE;
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: doc/cpu_sram_arbiter.md
CPU_SRAM_ARBITER -- requirements
Module: cpu_sram_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 4, SHALL set the consecutive data grants allowed while inst waits (range 1..15).
REQ-002 clk  in  1  sole clock; all state SHALL update on its rising edge.
REQ-003 reset  in  1  synchronous, active-high reset, sampled on rising clk.
REQ-004 inst_req  in  1  fetch request; held by requester until inst_addr_ok.
REQ-005 inst_addr  in  32  fetch address (read-only port).
REQ-006 inst_addr_ok  out  1  fetch address accepted by memory.
REQ-007 inst_data_ok  out  1  fetch read data valid on inst_rdata.
REQ-008 inst_rdata  out  32  fetch read data.
REQ-009 data_req  in  1  load/store request; held until data_addr_ok.
REQ-010 data_wr  in  1  1 = store, 0 = load.
REQ-011 data_wstrb  in  4  byte write strobes (store only).
REQ-012 data_addr  in  32  load/store address.
REQ-013 data_wdata  in  32  store data.
REQ-014 data_addr_ok  out  1  data address accepted.
REQ-015 data_data_ok  out  1  load data valid / store complete.
REQ-016 data_rdata  out  32  load data.
REQ-017 mem_req  out  1  shared-port request.
REQ-018 mem_wr  out  1  shared-port write flag.
REQ-019 mem_wstrb  out  4  shared-port strobes.
REQ-020 mem_addr  out  32  shared-port address.
REQ-021 mem_wdata  out  32  shared-port write data.
REQ-022 mem_addr_ok  in  1  slave accepted address.
REQ-023 mem_data_ok  in  1  slave response; never in the same cycle as its mem_addr_ok.
REQ-024 mem_rdata  in  32  slave read data.

Function
REQ-025 The block SHALL hold exactly one outstanding transaction; FSM states IDLE, ADDR, RESP.
REQ-026 IDLE: if any request pending, SHALL register owner (INST/DATA) and go to ADDR next cycle; else stay IDLE.
REQ-027 Arbitration: data SHALL win over inst, except inst SHALL win when both pending and starve_cnt == STARVE_LIMIT.
REQ-028 starve_cnt (4 bits) SHALL increment on a data grant with inst_req high, clear on any inst grant, hold otherwise; never exceed STARVE_LIMIT.
REQ-029 ADDR: mem_req SHALL equal owner's req; mem_addr/mem_wr/mem_wstrb/mem_wdata SHALL be owner's inputs combinationally (inst: mem_wr=0, mem_wstrb=0, mem_wdata=0).
REQ-030 ADDR: owner's addr_ok SHALL equal mem_addr_ok same cycle; on mem_addr_ok go to RESP.
REQ-031 RESP: mem_req SHALL be 0; owner's data_ok SHALL equal mem_data_ok same cycle; on mem_data_ok go to IDLE.
REQ-032 inst_rdata and data_rdata SHALL both be driven with mem_rdata ungated.
REQ-033 Non-owner addr_ok/data_ok SHALL be 0 always; all *_ok outputs SHALL be 0 in IDLE.
REQ-034 mem_data_ok outside RESP and mem_addr_ok outside ADDR SHALL be ignored (no state change, no forwarding).
REQ-035 Minimum latency: req in cycle 0 -> mem_req cycle 1 -> (addr_ok cycle 1) -> data_ok earliest cycle 2 -> next grant decision cycle 3.
REQ-036 Owner dropping req in ADDR SHALL drop mem_req; FSM SHALL remain in ADDR until mem_addr_ok.
REQ-037 All outputs SHALL be combinational from state/owner/inputs as above; no output depends on unregistered arbitration in IDLE.

Reset
REQ-038 reset SHALL force state=IDLE, owner=INST, starve_cnt=0 on the next rising edge, overriding any transaction in flight.
REQ-039 During and after reset until a grant, mem_req and all *_ok outputs SHALL be 0.
REQ-040 A slave response arriving after mid-transaction reset SHALL be ignored per REQ-034.

Verification
REQ-041 Single fetch: inst_req=1, inst_addr=0x1C000000, slave addr_ok cycle 1, data_ok cycle 3 with rdata=0x02800C0C -> inst_data_ok=1, inst_rdata=0x02800C0C in cycle 3, data_* oks stay 0.
REQ-042 Simultaneous: inst_req and data_req (load 0x0000_1000) both high cycle 0 -> mem_addr=0x00001000 in cycle 1; inst granted only after data_data_ok.
REQ-043 Starvation: data_req held high continuously, inst_req high, STARVE_LIMIT=4 -> grant sequence D,D,D,D,I,D...; starve_cnt back to 0 after I.
REQ-044 Store: data_wr=1, wstrb=4'b0011, wdata=0xDEADBEEF, addr 0x8 -> mem_wr=1, mem_wstrb=4'b0011, mem_wdata=0xDEADBEEF in ADDR; data_data_ok on slave response.
REQ-045 Reset in RESP: reset pulsed 1 cycle, then stray mem_data_ok=1 -> no *_data_ok asserted, state IDLE, mem_req=0.
REQ-046 Slave backpressure: mem_addr_ok low 5 cycles -> mem_req and mem_addr held stable, no *_addr_ok until 6th cycle.
